// File: rtl/rs_logical_issue.sv
// rtl/rs_logical_issue.sv - reservation station and round-robin issue stage for the logical FU
// Entries capture operands from dispatch or CDB; one fully-ready entry per cycle moves into a registered output stage.
module rs_logical_issue #(
    parameter int DEPTH = 4,
    parameter int PRN_W = 7,
    parameter int ID_W  = 6,
    parameter int NOPS  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic [31:0]                alloc_inst,
    input  logic [ID_W-1:0]            alloc_inst_id,
    input  logic [3*PRN_W-1:0]         alloc_out_prn,
    input  logic [NOPS*PRN_W-1:0]      alloc_op_prn,
    input  logic [NOPS-1:0]            alloc_op_rdy,
    input  logic [NOPS*64-1:0]         alloc_op_data,
    input  logic                       cdb_valid,
    input  logic [PRN_W-1:0]           cdb_prn,
    input  logic [63:0]                cdb_data,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [31:0]                issue_inst,
    output logic [ID_W-1:0]            issue_inst_id,
    output logic [3*PRN_W-1:0]         issue_out_prn,
    output logic [NOPS*64-1:0]         issue_op,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [DEPTH-1:0]                        valid_q, valid_d;
    logic [DEPTH-1:0][31:0]                  inst_q, inst_d;
    logic [DEPTH-1:0][ID_W-1:0]              id_q, id_d;
    logic [DEPTH-1:0][3*PRN_W-1:0]           dst_q, dst_d;
    logic [DEPTH-1:0][NOPS-1:0][PRN_W-1:0]   src_q, src_d;
    logic [DEPTH-1:0][NOPS-1:0]              rdy_q, rdy_d;
    logic [DEPTH-1:0][NOPS-1:0][63:0]        data_q, data_d;

    logic [IDX_W-1:0]      rr_q, rr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  iss_valid_q, iss_valid_d;
    logic [31:0]           iss_inst_q, iss_inst_d;
    logic [ID_W-1:0]       iss_id_q, iss_id_d;
    logic [3*PRN_W-1:0]    iss_dst_q, iss_dst_d;
    logic [NOPS*64-1:0]    iss_op_q, iss_op_d;

    logic                  free_found;
    logic [IDX_W-1:0]      free_idx;
    logic [DEPTH-1:0]      elig;
    logic                  sel_found;
    logic [IDX_W-1:0]      sel_idx;
    logic [IDX_W-1:0]      cand;
    logic                  load;
    logic                  do_issue;
    logic                  do_alloc;
    logic [PRN_W-1:0]      a_prn;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            elig[i] = valid_q[i] && (&rdy_q[i]);
        end
    end

    // Round-robin search starting at rr_q; power-of-two DEPTH makes the wrap free.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            cand = rr_q + IDX_W'(k);
            if (!sel_found && elig[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign alloc_ready = free_found;
    assign load        = !iss_valid_q || issue_ready;
    assign do_issue    = load && sel_found && !flush;
    assign do_alloc    = alloc_valid && free_found && !flush;

    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        id_d    = id_q;
        dst_d   = dst_q;
        src_d   = src_q;
        rdy_d   = rdy_q;
        data_d  = data_q;
        a_prn   = '0;
        if (flush) begin
            valid_d = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < NOPS; j++) begin
                    if (valid_q[i] && !rdy_q[i][j] && cdb_valid && (cdb_prn == src_q[i][j])) begin
                        rdy_d[i][j]  = 1'b1;
                        data_d[i][j] = cdb_data;
                    end
                end
            end
            if (do_issue) begin
                valid_d[sel_idx] = 1'b0;
            end
            // The free slot is never the selected one, so these writes cannot collide with the issue clear.
            if (do_alloc) begin
                valid_d[free_idx] = 1'b1;
                inst_d[free_idx]  = alloc_inst;
                id_d[free_idx]    = alloc_inst_id;
                dst_d[free_idx]   = alloc_out_prn;
                for (int j = 0; j < NOPS; j++) begin
                    a_prn                    = alloc_op_prn[j*PRN_W +: PRN_W];
                    src_d[free_idx][j]       = a_prn;
                    if (alloc_op_rdy[j]) begin
                        rdy_d[free_idx][j]  = 1'b1;
                        data_d[free_idx][j] = alloc_op_data[j*64 +: 64];
                    end else if (cdb_valid && (cdb_prn == a_prn)) begin
                        rdy_d[free_idx][j]  = 1'b1;
                        data_d[free_idx][j] = cdb_data;
                    end else begin
                        rdy_d[free_idx][j]  = 1'b0;
                        data_d[free_idx][j] = alloc_op_data[j*64 +: 64];
                    end
                end
            end
        end
    end

    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_inst_d  = iss_inst_q;
        iss_id_d    = iss_id_q;
        iss_dst_d   = iss_dst_q;
        iss_op_d    = iss_op_q;
        rr_d        = rr_q;
        if (flush) begin
            iss_valid_d = 1'b0;
        end else if (do_issue) begin
            iss_valid_d = 1'b1;
            iss_inst_d  = inst_q[sel_idx];
            iss_id_d    = id_q[sel_idx];
            iss_dst_d   = dst_q[sel_idx];
            iss_op_d    = data_q[sel_idx];
            rr_d        = sel_idx + 1'b1;
        end else if (load) begin
            iss_valid_d = 1'b0;
        end
    end

    always_comb begin
        if (flush) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(do_alloc) - CNT_W'(do_issue);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            inst_q      <= '0;
            id_q        <= '0;
            dst_q       <= '0;
            src_q       <= '0;
            rdy_q       <= '0;
            data_q      <= '0;
            rr_q        <= '0;
            cnt_q       <= '0;
            iss_valid_q <= 1'b0;
            iss_inst_q  <= '0;
            iss_id_q    <= '0;
            iss_dst_q   <= '0;
            iss_op_q    <= '0;
        end else begin
            valid_q     <= valid_d;
            inst_q      <= inst_d;
            id_q        <= id_d;
            dst_q       <= dst_d;
            src_q       <= src_d;
            rdy_q       <= rdy_d;
            data_q      <= data_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            iss_valid_q <= iss_valid_d;
            iss_inst_q  <= iss_inst_d;
            iss_id_q    <= iss_id_d;
            iss_dst_q   <= iss_dst_d;
            iss_op_q    <= iss_op_d;
        end
    end

    assign issue_valid   = iss_valid_q;
    assign issue_inst    = iss_inst_q;
    assign issue_inst_id = iss_id_q;
    assign issue_out_prn = iss_dst_q;
    assign issue_op      = iss_op_q;
    assign occupancy     = cnt_q;

endmodule

// File: tb/tb_rs_logical_issue.sv
// tb/tb_rs_logical_issue.sv - scoreboard bench for rs_logical_issue
// Directed scenarios followed by randomized dispatch/CDB/backpressure traffic.
module tb_rs_logical_issue;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          alloc_valid;
    logic          alloc_ready;
    logic [31:0]   alloc_inst;
    logic [5:0]    alloc_inst_id;
    logic [20:0]   alloc_out_prn;
    logic [20:0]   alloc_op_prn;
    logic [2:0]    alloc_op_rdy;
    logic [191:0]  alloc_op_data;
    logic          cdb_valid;
    logic [6:0]    cdb_prn;
    logic [63:0]   cdb_data;
    logic          issue_valid;
    logic          issue_ready;
    logic [31:0]   issue_inst;
    logic [5:0]    issue_inst_id;
    logic [20:0]   issue_out_prn;
    logic [191:0]  issue_op;
    logic [2:0]    occupancy;

    rs_logical_issue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_inst(alloc_inst), .alloc_inst_id(alloc_inst_id),
        .alloc_out_prn(alloc_out_prn), .alloc_op_prn(alloc_op_prn),
        .alloc_op_rdy(alloc_op_rdy), .alloc_op_data(alloc_op_data),
        .cdb_valid(cdb_valid), .cdb_prn(cdb_prn), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_inst(issue_inst), .issue_inst_id(issue_inst_id),
        .issue_out_prn(issue_out_prn), .issue_op(issue_op),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  inst;
        logic [5:0]   id;
        logic [20:0]  out_prn;
        logic [191:0] op;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] val_tbl [128];
    logic [6:0]  pending[$];
    bit          ordered = 1'b1;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Every accepted dispatch becomes an expected issue; unready operands resolve to the PRN's broadcast value.
    always @(negedge clk) begin
        if (!rst && !flush && alloc_valid && alloc_ready) begin
            exp_t e;
            e.inst    = alloc_inst;
            e.id      = alloc_inst_id;
            e.out_prn = alloc_out_prn;
            for (int j = 0; j < 3; j++) begin
                e.op[j*64 +: 64] = alloc_op_rdy[j] ? alloc_op_data[j*64 +: 64]
                                                   : val_tbl[alloc_op_prn[j*7 +: 7]];
            end
            sb.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (!rst && issue_valid && issue_ready) begin
            int idx;
            idx = -1;
            for (int i = 0; i < sb.size(); i++) begin
                if (idx < 0 && sb[i].id == issue_inst_id) idx = i;
            end
            if (idx < 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual_id=%0d required=none_outstanding", issue_inst_id);
            end else begin
                if (ordered) chk("sb_order", 64'(idx), 64'd0);
                chk("sb_inst", issue_inst, sb[idx].inst);
                chk("sb_out_prn", issue_out_prn, sb[idx].out_prn);
                for (int j = 0; j < 3; j++) begin
                    chk("sb_op", issue_op[j*64 +: 64], sb[idx].op[j*64 +: 64]);
                end
                sb.delete(idx);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 1'b0;
        cdb_valid   = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic set_alloc(input logic [5:0] id, input logic [2:0] rdy,
                             input logic [20:0] prns, input logic [191:0] data);
        alloc_valid   = 1'b1;
        alloc_inst    = 32'hAA00_0000 | 32'(id);
        alloc_inst_id = id;
        alloc_out_prn = {7'(id), 7'(id + 1), 7'(id + 2)};
        alloc_op_prn  = prns;
        alloc_op_rdy  = rdy;
        alloc_op_data = data;
    endtask

    task automatic bcast(input logic [6:0] p);
        cdb_valid = 1'b1;
        cdb_prn   = p;
        cdb_data  = val_tbl[p];
    endtask

    int          exp_ids[5] = '{10, 11, 12, 13, 14};
    logic [31:0] held_inst;
    logic        acc;
    logic [2:0]  r_rdy;
    logic [20:0] r_prn;
    logic [5:0]  next_id;
    int          drain;

    initial begin
        for (int p = 0; p < 128; p++) val_tbl[p] = {$urandom, $urandom};
        val_tbl[9] = 64'h4;
        rst = 1'b1; idle();
        issue_ready = 1'b1;
        alloc_inst = '0; alloc_inst_id = '0; alloc_out_prn = '0;
        alloc_op_prn = '0; alloc_op_rdy = '0; alloc_op_data = '0;
        cdb_prn = '0; cdb_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_issue_inst", issue_inst, 0);
        chk("rst_issue_op", issue_op[63:0], 0);
        rst = 1'b0;
        tick();

        // Ready at dispatch: issue visible one edge after allocation.
        set_alloc(6'd1, 3'b111, 21'd0, {64'h0, 64'h0F, 64'hF0});
        tick(); idle();
        chk("rad_occ_e1", occupancy, 1);
        chk("rad_valid_e1", issue_valid, 0);
        tick();
        chk("rad_valid_e2", issue_valid, 1);
        chk("rad_op0", issue_op[63:0], 64'hF0);
        chk("rad_op1", issue_op[127:64], 64'h0F);
        chk("rad_occ_e2", occupancy, 0);
        tick();
        chk("rad_valid_e3", issue_valid, 0);

        // Same-edge CDB bypass into the allocation write.
        set_alloc(6'd2, 3'b011, {7'd9, 7'd0, 7'd0}, {64'hDEAD, 64'h2, 64'h1});
        bcast(7'd9);
        tick(); idle();
        chk("byp_valid_e1", issue_valid, 0);
        tick();
        chk("byp_valid_e2", issue_valid, 1);
        chk("byp_op2", issue_op[191:128], 64'h4);
        tick();

        // CDB one edge later delays issue by one cycle.
        set_alloc(6'd3, 3'b011, {7'd9, 7'd0, 7'd0}, {64'hDEAD, 64'h2, 64'h1});
        tick(); idle();
        bcast(7'd9);
        tick(); idle();
        chk("wake_valid_e2", issue_valid, 0);
        tick();
        chk("wake_valid_e3", issue_valid, 1);
        chk("wake_op2", issue_op[191:128], 64'h4);
        tick();

        // Backpressure: the stage holds while issue_ready is low.
        issue_ready = 1'b0;
        set_alloc(6'd4, 3'b111, 21'd0, {64'h44, 64'h43, 64'h42});
        tick();
        set_alloc(6'd5, 3'b111, 21'd0, {64'h55, 64'h54, 64'h53});
        tick(); idle();
        chk("bp_first_id", issue_inst_id, 4);
        held_inst = issue_inst;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_hold_valid", issue_valid, 1);
            chk("bp_hold_id", issue_inst_id, 4);
            chk("bp_hold_inst", issue_inst, held_inst);
        end
        chk("bp_occ", occupancy, 1);
        issue_ready = 1'b1;
        tick();
        chk("bp_second_id", issue_inst_id, 5);
        tick();
        chk("bp_drained", issue_valid, 0);

        // Asynchronous reset between edges with a busy station and a held stage.
        issue_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_alloc(6'(6 + k), 3'b111, 21'd0, {3{64'(k)}});
            tick();
        end
        idle();
        chk("mid_pre_occ", occupancy, 3);
        chk("mid_pre_valid", issue_valid, 1);
        #3;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_valid", issue_valid, 0);
        chk("mid_rst_occ", occupancy, 0);
        chk("mid_rst_ready", alloc_ready, 1);
        chk("mid_rst_id", issue_inst_id, 0);
        tick();
        rst = 1'b0;
        issue_ready = 1'b1;

        // Round-robin: four waiting entries woken together, slot 0 refilled after the first issue.
        for (int k = 0; k < 4; k++) begin
            set_alloc(6'(10 + k), 3'b110, {7'd0, 7'd0, 7'd20}, {64'h1, 64'h2, 64'h0});
            tick();
        end
        idle();
        chk("rr_full_ready", alloc_ready, 0);
        chk("rr_full_occ", occupancy, 4);
        chk("rr_full_valid", issue_valid, 0);
        set_alloc(6'd24, 3'b111, 21'd0, {3{64'h24}});
        bcast(7'd20);
        tick(); idle();
        chk("rr_fifth_rejected_occ", occupancy, 4);
        chk("rr_full_issuing_ready", alloc_ready, 0);
        tick();
        chk("rr_id0", issue_inst_id, 6'(exp_ids[0]));
        chk("rr_occ_after_first", occupancy, 3);
        chk("rr_ready_after_first", alloc_ready, 1);
        set_alloc(6'd14, 3'b111, 21'd0, {64'hE2, 64'hE1, 64'hE0});
        tick(); idle();
        chk("rr_id1", issue_inst_id, 6'(exp_ids[1]));
        chk("rr_occ_alloc_and_issue", occupancy, 3);
        for (int k = 2; k < 5; k++) begin
            tick();
            chk("rr_id", issue_inst_id, 6'(exp_ids[k]));
        end
        tick();
        chk("rr_done", issue_valid, 0);

        // Full station plus held stage, then flush with a CDB on the flush edge.
        issue_ready = 1'b0;
        set_alloc(6'd19, 3'b111, 21'd0, {3{64'h19}});
        tick();
        for (int k = 0; k < 4; k++) begin
            set_alloc(6'(20 + k), 3'b011, {7'd30, 7'd0, 7'd0}, {3{64'h0}});
            tick();
        end
        idle();
        chk("fl_pre_occ", occupancy, 4);
        chk("fl_pre_valid", issue_valid, 1);
        chk("fl_pre_ready", alloc_ready, 0);
        flush = 1'b1;
        bcast(7'd30);
        tick(); idle();
        chk("fl_occ", occupancy, 0);
        chk("fl_valid", issue_valid, 0);
        chk("fl_ready", alloc_ready, 1);
        sb.delete();
        issue_ready = 1'b1;
        tick(); tick();
        chk("fl_no_wake", issue_valid, 0);
        chk("fl_occ_stays", occupancy, 0);

        // Randomized traffic; the scoreboard matches issues by instruction id.
        ordered = 1'b0;
        next_id = 6'd32;
        for (int c = 0; c < 800; c++) begin
            r_rdy = 3'($urandom);
            r_prn = 21'($urandom);
            set_alloc(next_id, r_rdy, r_prn, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            alloc_inst    = $urandom;
            alloc_out_prn = 21'($urandom);
            alloc_valid   = ($urandom_range(0, 9) < 6);
            if (pending.size() > 0 && $urandom_range(0, 9) < 4) begin
                bcast(pending[$urandom_range(0, pending.size() - 1)]);
            end else if ($urandom_range(0, 9) == 0) begin
                bcast(7'($urandom));
            end else begin
                cdb_valid = 1'b0;
            end
            issue_ready = ($urandom_range(0, 9) < 7);
            acc = alloc_valid && alloc_ready;
            tick();
            if (cdb_valid) begin
                for (int i = pending.size() - 1; i >= 0; i--) begin
                    if (pending[i] == cdb_prn) pending.delete(i);
                end
            end
            if (acc) begin
                next_id = next_id + 6'd1;
                for (int j = 0; j < 3; j++) begin
                    if (!r_rdy[j] && !(cdb_valid && cdb_prn == r_prn[j*7 +: 7])) begin
                        pending.push_back(r_prn[j*7 +: 7]);
                    end
                end
            end
        end

        idle();
        issue_ready = 1'b1;
        drain = 0;
        while ((pending.size() > 0 || sb.size() > 0) && drain < 300) begin
            if (pending.size() > 0) bcast(pending[0]);
            else cdb_valid = 1'b0;
            tick();
            if (cdb_valid) begin
                for (int i = pending.size() - 1; i >= 0; i--) begin
                    if (pending[i] == cdb_prn) pending.delete(i);
                end
            end
            drain++;
        end
        idle();
        tick();
        chk("rand_sb_empty", 64'(sb.size()), 0);
        chk("rand_occ", occupancy, 0);
        chk("rand_valid", issue_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
